gestion_ad_review: RTL
======================

Name: gestion_ad_review

Overview:
Parametrised address manager for the record/review sample memory. In normal mode it generates sequential write addresses and tracks the last written address and fill level. In review mode it provides a read pointer that the user steps backward (RetourArriere) and forward (Avance) through recorded data, bounded to valid samples. Optional circular recording is supported. It sits between the user button/mode debouncers and the sample RAM address ports.

Parameters:
ADDR_W, 7, address width; DEPTH = 2**ADDR_W words
POLARITY_RA, 1, RetourArriere active edge: 1 = rising, 0 = falling
POLARITY_AV, 1, Avance active edge: 1 = rising, 0 = falling
MODE, 1, Mode polarity: 1 means Mode=1 is normal; 0 means Mode=0 is normal
WRAP, 0, 0 = stop recording when full; 1 = circular, overwrite oldest

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
Mode  in  1  normal/review select, after MODE polarity: 1 normal, 0 review
WriteEn  in  1  one-cycle strobe: a sample is written at AdWrite this cycle
RetourArriere  in  1  step-back button level, already debounced
Avance  in  1  step-forward button level, already debounced
AdWrite  out  ADDR_W  next write address
AdRead  out  ADDR_W  review read address
AdMax  out  ADDR_W  address of most recently written sample
Full  out  1  DEPTH samples held
Empty  out  1  no sample written since reset
Review  out  1  1 while in REVIEW state

Behaviour:
- One clock; reset is synchronous and active-high, named Clk and Reset.
- Reset has priority over all other inputs in the same cycle. Reset values: AdWrite=0, AdRead=0, AdMax=0, Full=0, Empty=1, Review=0, state=NORMAL, internal count=0. Edge-detect history registers reset to 1, so a button held through reset produces no pulse.
- Polarity is applied combinationally to RetourArriere and Avance. The result is registered once.
- Step pulses: raStep = pol_now & ~pol_prev; avStep likewise. A step is processed in the cycle after the active edge. Output registers update one clock after that.
- Internal count is ADDR_W+1 bits, range 0..DEPTH. Full = (count == DEPTH). oldest = (WRAP && Full) ? AdWrite : 0.
- State NORMAL:
  - On WriteEn, when not (Full && !WRAP): AdMax <= AdWrite; AdWrite <= AdWrite+1, wrapping mod DEPTH; count increments, saturating at DEPTH; Empty <= 0.
  - WriteEn while Full with WRAP=0: ignored, with no change.
  - Step pulses are ignored. AdRead holds.
- NORMAL -> REVIEW when PolMode==0 is sampled. In that same edge: Review <= 1, AdRead <= AdMax, and any step pulse is dropped.
- State REVIEW:
  - WriteEn is ignored.
  - raStep: AdRead <= AdRead-1, mod DEPTH, unless AdRead == oldest. At the lower bound, hold.
  - avStep: AdRead <= AdRead+1, mod DEPTH, unless AdRead == AdMax. At the upper bound, hold.
  - raStep and avStep in the same cycle: no move.
  - Empty=1: all steps ignored; AdRead stays 0.
- REVIEW -> NORMAL when PolMode==1 is sampled. Review <= 0. AdRead holds its last value. Recording resumes at AdWrite, continuing the existing data, not restarting.
- Circular mode (WRAP=1, Full): valid window is oldest..AdMax going upward mod DEPTH. Stepping back through address 0 wraps to DEPTH-1 when that address is in the window.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Case 1, ADDR_W=3, WRAP=0. Stimulus: reset, then 5 WriteEn strobes in NORMAL. Required: AdWrite=5, AdMax=4, Empty=0, Full=0, AdRead=0.
- Case 2, continuing Case 1. Stimulus: Mode->0, then 2 RetourArriere rising edges, then 1 Avance edge. Required: Review=1, AdRead goes 4 -> 3 -> 2 -> 3. Each update appears 2 clocks after its edge.
- Case 3, lower/upper bounds. Stimulus: in REVIEW, 6 RA edges, then 10 AV edges. Required: AdRead stops at 0, then stops at 4. A simultaneous RA+AV edge leaves AdRead unchanged.
- Case 4, ADDR_W=3, WRAP=0 full. Stimulus: 10 WriteEn strobes. Required: Full=1 after the 8th, AdMax=7, AdWrite=0; strobes 9 and 10 are ignored.
- Case 5, WRAP=1. Stimulus: 11 WriteEn strobes, then review. Required: AdMax=2, AdWrite=3, Full=1. RA edges step AdRead 2 -> 1 -> 0 -> 7 -> … -> 3 and stop at 3 (oldest).
- Case 6, reset mid-review. Stimulus: assert Reset while RA is held high. Required: all reset values appear the next clock; releasing Reset with RA still high produces no step. POLARITY_RA=0 variant: a falling edge steps AdRead.

Source files
------------

// File: rtl/gestion_ad_review_if.sv
// rtl/gestion_ad_review_if.sv - control and address signals of the record/review address manager
interface gestion_ad_review_if #(
  parameter int ADDR_W = 7
);
  logic              Mode;
  logic              WriteEn;
  logic              RetourArriere;
  logic              Avance;
  logic [ADDR_W-1:0] AdWrite;
  logic [ADDR_W-1:0] AdRead;
  logic [ADDR_W-1:0] AdMax;
  logic              Full;
  logic              Empty;
  logic              Review;

  modport master (
    output Mode, WriteEn, RetourArriere, Avance,
    input  AdWrite, AdRead, AdMax, Full, Empty, Review
  );

  modport slave (
    input  Mode, WriteEn, RetourArriere, Avance,
    output AdWrite, AdRead, AdMax, Full, Empty, Review
  );
endinterface

// File: rtl/gestion_ad_review.sv
// rtl/gestion_ad_review.sv - sample memory write/review address manager with bounded step-through
module gestion_ad_review #(
  parameter int ADDR_W      = 7,
  parameter int POLARITY_RA = 1,
  parameter int POLARITY_AV = 1,
  parameter int MODE        = 1,
  parameter int WRAP        = 0
) (
  input logic               Clk,
  input logic               Reset,
  gestion_ad_review_if.slave bus
);

  typedef enum logic {NORMAL, REVIEW} state_t;

  state_t            state;
  logic              ra_now, ra_prev, av_now, av_prev;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] ad_write, ad_read, ad_max;
  logic              empty, review;

  logic              pol_mode, ra_step, av_step, full;
  logic [ADDR_W-1:0] oldest;

  assign pol_mode = (MODE != 0) ? bus.Mode : ~bus.Mode;
  assign ra_step  = ra_now & ~ra_prev;
  assign av_step  = av_now & ~av_prev;
  // count never exceeds DEPTH, so its top bit alone marks the full condition
  assign full     = count[ADDR_W];
  assign oldest   = ((WRAP != 0) && full) ? ad_write : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= NORMAL;
      ra_now   <= 1'b1;
      ra_prev  <= 1'b1;
      av_now   <= 1'b1;
      av_prev  <= 1'b1;
      count    <= '0;
      ad_write <= '0;
      ad_read  <= '0;
      ad_max   <= '0;
      empty    <= 1'b1;
      review   <= 1'b0;
    end else begin
      ra_now  <= (POLARITY_RA != 0) ? bus.RetourArriere : ~bus.RetourArriere;
      ra_prev <= ra_now;
      av_now  <= (POLARITY_AV != 0) ? bus.Avance : ~bus.Avance;
      av_prev <= av_now;
      case (state)
        NORMAL: begin
          if (!pol_mode) begin
            state   <= REVIEW;
            review  <= 1'b1;
            ad_read <= ad_max;
          end
          if (bus.WriteEn && !(full && (WRAP == 0))) begin
            ad_max   <= ad_write;
            ad_write <= ad_write + 1'b1;
            if (!full) count <= count + 1'b1;
            empty    <= 1'b0;
          end
        end
        REVIEW: begin
          if (pol_mode) begin
            state  <= NORMAL;
            review <= 1'b0;
          end else if (!empty && (ra_step ^ av_step)) begin
            // window is oldest..ad_max going upward, so the bounds are plain equality tests
            if (ra_step && (ad_read != oldest)) ad_read <= ad_read - 1'b1;
            if (av_step && (ad_read != ad_max)) ad_read <= ad_read + 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  assign bus.AdWrite = ad_write;
  assign bus.AdRead  = ad_read;
  assign bus.AdMax   = ad_max;
  assign bus.Full    = full;
  assign bus.Empty   = empty;
  assign bus.Review  = review;

endmodule
